fir_decimator: RTL
==================

Name: fir_decimator

Overview:
Output stage placed directly downstream of the FIR filter top entity. It takes the filter's signed 16-bit output stream and decimates it by 2^LOG2_R using integrate-and-dump averaging with round-half-up. Results are buffered in a small FIFO and presented on a valid/ready interface, so downstream consumers can apply backpressure without stalling the filter.

Parameters:
LOG2_R, 2, log2 of the decimation ratio R. Legal range 0..4. A value of 0 means pass-through with one cycle of latency.
FIFO_DEPTH, 4, number of output FIFO entries. Must be a power of two and at least 2.

Ports:
system1000  input  1  clock; all logic runs on its rising edge
system1000_rstn  input  1  reset, synchronous, active-low
in_sample  input  16  signed FIR output sample
in_valid  input  1  in_sample is valid this cycle; no ready is returned, so the block always accepts
out_sample  output  16  signed decimated sample, taken from the FIFO head
out_valid  output  1  FIFO is not empty
out_ready  input  1  consumer accepts out_sample this cycle
overflow  output  1  sticky flag: a result was dropped because the FIFO was full
ovf_clr  input  1  clears overflow
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: on a rising edge with system1000_rstn=0, the following are cleared.
  - acc=0, phase=0, FIFO empty.
  - out_valid=0, out_sample=0, overflow=0, fifo_level=0.
  - Reset overrides every other input. A partial frame in progress is discarded.
- Accumulator: signed, 16+LOG2_R bits wide. Phase counter is LOG2_R bits and counts 0..R-1.
- On an edge with in_valid=1 and phase<R-1: acc<=acc+in_sample; phase<=phase+1.
- On an edge with in_valid=1 and phase==R-1 (dump):
  - sum=acc+in_sample.
  - result=(sum+2^(LOG2_R-1))>>>LOG2_R (arithmetic shift). For LOG2_R=0 there is no rounding term.
  - Saturate result to [-32768, 32767]. This is mathematically unreachable, but the guard is required.
  - Push result into the FIFO. Then acc<=0 and phase<=0.
- in_valid=0: acc and phase hold. Gaps in the input stream are legal.
- Latency: the result is written at the edge that accepts the final sample of the frame. out_valid is high in the following cycle.
- Pop: an edge with out_valid=1 and out_ready=1 removes the head entry. out_sample shows the new head, or holds its last value when the FIFO becomes empty. out_sample is stable while out_valid=1 and out_ready=0.
- Push and pop on the same edge are both performed, with fifo_level unchanged. This also applies when the FIFO is full, so no drop occurs.
- Push into a full FIFO with no pop on the same edge:
  - The new result is dropped and the FIFO contents are unchanged.
  - overflow<=1 on that edge.
- overflow is sticky until an edge with ovf_clr=1. If ovf_clr and a new drop occur on the same edge, the drop wins and overflow=1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is the true occupancy in the range 0..FIFO_DEPTH.
- All outputs are registered or driven directly from registers. There are no combinational paths from in_* to out_*.

Decomposition:
- fir_pkg holds:
  - SAMPLE_W=16
  - typedef logic signed [SAMPLE_W-1:0] sample_t
  - function sat16, used by both this block and the filter.
- Sub-module fir_dec_fifo: a synchronous FIFO with the same clock/reset pair. It provides push/pop/full/empty/level, width sample_t, depth FIFO_DEPTH, and implements the push+pop-when-full rule.
- fir_decimator contains the accumulator, phase counter, rounding, overflow flag and a fir_dec_fifo instance.

Test Plan:
1. LOG2_R=2, out_ready=1, eight consecutive samples of 1000 -> two outputs of 1000, each out_valid one cycle after the 4th/8th sample; overflow=0.
2. Rounding: inputs 1,2,3,4 -> out_sample 3 ((10+2)>>>2). Inputs -1,-1,-1,-2 -> out_sample -1 ((-5+2)>>>2). Four samples of -32768 -> -32768. Four of 32767 -> 32767.
3. in_valid gaps: samples 4,_,8,_,_,12,16 (where _ means in_valid=0) -> one output of 10, produced one cycle after the sample 16.
4. Backpressure: out_ready=0, 20 samples of 7 -> fifo_level=4 after the 4th result and the 5th result is dropped with overflow=1. Then out_ready=1 -> exactly four 7s drain and fifo_level=0. Pulse ovf_clr -> overflow=0.
5. Full with a simultaneous pop: FIFO full, out_ready=1 on the same edge as a dump -> no drop, fifo_level stays 4, overflow stays 0.
6. Reset mid-frame: two samples of 100, system1000_rstn=0 for one edge, then four samples of 8 -> single output of 8; out_valid was 0 during reset.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR types and helpers: sample width, sample type and a 16-bit saturator.
package fir_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Clamp a wide signed value into the signed 16-bit sample range.
    function automatic sample_t sat16(input logic signed [31:0] value);
        sample_t result;
        if (value > 32'sd32767) begin
            result = 16'sh7FFF;
        end else if (value < -32'sd32768) begin
            result = 16'sh8000;
        end else begin
            result = value[SAMPLE_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// Small synchronous FIFO for decimated samples with a registered head output.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module fir_dec_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  din,
    output sample_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    sample_t            mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               pop_ok;
    logic               push_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage array; contents only matter between the pointers, so it needs no reset.
    always_ff @(posedge system1000) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head value.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (PTR_W+1)'(1);
            end
            if (pop_ok) begin
                if (count > (PTR_W+1)'(1)) begin
                    head <= mem[rd_ptr + PTR_W'(1)];
                end else if (push_ok) begin
                    head <= din;
                end
            end else if (empty && push_ok) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator by 2^LOG2_R with round-half-up, feeding an
// output FIFO on a valid/ready interface with a sticky overflow flag.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int LOG2_R     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          system1000,
    input  logic                          system1000_rstn,
    input  sample_t                       in_sample,
    input  logic                          in_valid,
    output sample_t                       out_sample,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int ACC_W = SAMPLE_W + LOG2_R;
    localparam int PH_W  = (LOG2_R > 0) ? LOG2_R : 1;
    localparam int R     = 1 << LOG2_R;
    localparam logic signed [31:0] ROUND = 32'((1 << LOG2_R) >> 1);

    logic signed [ACC_W-1:0] acc;
    logic [PH_W-1:0]         phase;
    logic                    dump;
    logic signed [31:0]      sum_wide;
    logic signed [31:0]      rounded;
    sample_t                 result;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;

    assign dump     = in_valid && (phase == PH_W'(R - 1));
    assign sum_wide = 32'(acc) + 32'(in_sample);
    assign rounded  = (sum_wide + ROUND) >>> LOG2_R;
    assign result   = sat16(rounded);
    assign out_valid = !fifo_empty;
    assign pop      = out_valid && out_ready;
    assign drop     = dump && fifo_full && !pop;

    // Accumulate accepted samples and restart the frame after each dump.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            acc   <= '0;
            phase <= '0;
        end else if (dump) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            acc   <= acc + ACC_W'(in_sample);
            phase <= phase + PH_W'(1);
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    fir_dec_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .push            (dump),
        .pop             (pop),
        .din             (result),
        .head            (out_sample),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .level           (fifo_level)
    );

endmodule
